// File: rtl/uart_msg_if.sv
// Character stream handshake between a message source and a UART sink.
interface uart_msg_if;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_char, out_valid, input out_ready);
  modport slave  (input out_char, out_valid, output out_ready);
endinterface

// File: rtl/uart_msg_source.sv
// Replays a fixed parameter-packed message over a valid/ready character port,
// optionally repeated with an idle gap between repetitions.
module uart_msg_source #(
  parameter int                   MSG_LEN   = 13,
  parameter logic [8*MSG_LEN-1:0] MSG       = "Hello World!\n",
  parameter int                   REPEAT    = 1,
  parameter int                   GAP       = 0,
  parameter int                   AUTOSTART = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  uart_msg_if.master        out,
  output logic              busy,
  output logic              done,
  output logic [15:0]       sent_count
);

  localparam int IW = (MSG_LEN > 1) ? $clog2(MSG_LEN)  : 1;
  localparam int RW = (REPEAT > 0)  ? $clog2(REPEAT+1) : 1;
  localparam int GW = (GAP > 0)     ? $clog2(GAP+1)    : 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(MSG_LEN - 1);
  localparam logic [RW-1:0] REP_LAST = RW'((REPEAT > 0) ? REPEAT - 1 : 0);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [RW-1:0]   rep_cnt_q, rep_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [15:0]     sent_count_q, sent_count_d;
  logic            xfer;
  logic [7:0]      char_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      rep_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      sent_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rep_cnt_q    <= rep_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      sent_count_q <= sent_count_d;
    end
  end

  // valid comes from registered state only, so out_ready never loops back to it
  assign xfer = (state_q == S_SEND) && out.out_ready;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rep_cnt_d    = rep_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    sent_count_d = sent_count_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start || (state_q == S_IDLE && AUTOSTART != 0)) begin
          state_d      = S_SEND;
          idx_d        = '0;
          rep_cnt_d    = '0;
          sent_count_d = '0;
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (sent_count_q != 16'hFFFF) sent_count_d = sent_count_q + 16'd1;
          if (idx_q != IDX_LAST) begin
            idx_d = idx_q + 1'b1;
          end else begin
            idx_d = '0;
            if (REPEAT != 0) rep_cnt_d = rep_cnt_q + 1'b1;
            if (REPEAT != 0 && rep_cnt_q == REP_LAST) begin
              state_d = S_DONE;
            end else if (GAP != 0) begin
              state_d   = S_GAP;
              gap_cnt_d = '0;
            end
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_SEND;
        else                       gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    char_sel = 8'h00;
    if (state_q == S_SEND) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        if (idx_q == IW'(i)) char_sel = MSG[8*(MSG_LEN-1-i) +: 8];
      end
    end
  end

  assign out.out_char  = char_sel;
  assign out.out_valid = (state_q == S_SEND);
  assign busy          = (state_q == S_SEND) || (state_q == S_GAP);
  assign done          = (state_q == S_DONE);
  assign sent_count    = sent_count_q;

endmodule

// File: tb/tb_uart_msg_source.sv
// Bench for uart_msg_source: four parameterisations share clock and reset,
// checked one at a time with a vector table and a character scoreboard.
module tb_uart_msg_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [3:0]       start;
  logic [3:0]       busy, done;
  logic [3:0][15:0] cnt;
  logic [3:0]       vld, rdy;
  logic [3:0][7:0]  chr;

  uart_msg_if if0();
  uart_msg_if if1();
  uart_msg_if if2();
  uart_msg_if if3();

  uart_msg_source d0 (.clk(clk), .rst(rst), .start(start[0]), .out(if0),
                      .busy(busy[0]), .done(done[0]), .sent_count(cnt[0]));
  uart_msg_source #(.REPEAT(3), .GAP(4)) d1 (.clk(clk), .rst(rst), .start(start[1]), .out(if1),
                      .busy(busy[1]), .done(done[1]), .sent_count(cnt[1]));
  uart_msg_source #(.AUTOSTART(0)) d2 (.clk(clk), .rst(rst), .start(start[2]), .out(if2),
                      .busy(busy[2]), .done(done[2]), .sent_count(cnt[2]));
  uart_msg_source #(.MSG_LEN(1), .MSG(8'h41), .REPEAT(0)) d3 (.clk(clk), .rst(rst), .start(start[3]),
                      .out(if3), .busy(busy[3]), .done(done[3]), .sent_count(cnt[3]));

  assign vld = {if3.out_valid, if2.out_valid, if1.out_valid, if0.out_valid};
  assign chr = {if3.out_char, if2.out_char, if1.out_char, if0.out_char};
  assign if0.out_ready = rdy[0];
  assign if1.out_ready = rdy[1];
  assign if2.out_ready = rdy[2];
  assign if3.out_ready = rdy[3];

  int         n_chk = 0;
  int         n_fail = 0;
  int         mon = -1;
  logic [7:0] sbq[$];
  logic [7:0] msg [13] = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20, 8'h57,
                           8'h6f, 8'h72, 8'h6c, 8'h64, 8'h21, 8'h0a};

  typedef struct {
    logic        rdy;
    logic        v;
    logic [7:0]  c;
    logic        b;
    logic        d;
    logic [15:0] n;
  } vec_t;
  vec_t tv [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock: commit the transfer seen before the edge, then check holds.
  task automatic tick();
    logic [3:0]      hold;
    logic [3:0][7:0] held;
    logic [7:0]      e;
    for (int k = 0; k < 4; k++) begin
      hold[k] = vld[k] & ~rdy[k] & ~rst;
      held[k] = chr[k];
    end
    if (mon >= 0 && vld[mon] && rdy[mon] && !rst) begin
      if (sbq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb_extra d%0d: got char %0h, expected no transfer", mon, chr[mon]);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("sb_char d%0d", mon), 32'(chr[mon]), 32'(e));
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (hold[k]) begin
        chk($sformatf("stall_valid d%0d", k), 32'(vld[k]), 32'd1);
        chk($sformatf("stall_char d%0d", k), 32'(chr[k]), 32'(held[k]));
      end
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = '0;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_valid d%0d", k), 32'(vld[k]), 32'd0);
      chk($sformatf("rst_busy d%0d", k),  32'(busy[k]), 32'd0);
      chk($sformatf("rst_done d%0d", k),  32'(done[k]), 32'd0);
      chk($sformatf("rst_count d%0d", k), 32'(cnt[k]), 32'd0);
    end
    rst = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    int n = 0;
    while (!done[k] && n < budget) begin
      tick();
      n++;
    end
    if (!done[k]) begin
      n_chk++; n_fail++;
      $display("FAIL timeout d%0d: done=0 after %0d cycles, expected 1", k, budget);
    end
  endtask

  task automatic push_msg();
    for (int i = 0; i < 13; i++) sbq.push_back(msg[i]);
  endtask

  initial begin
    int   guard;
    logic seen_done;
    rst   = 1'b1;
    start = '0;
    rdy   = 4'hF;

    for (int i = 0; i < 13; i++) tv[i] = '{1'b1, 1'b1, msg[i], 1'b1, 1'b0, 16'(i)};
    for (int i = 13; i < 15; i++) tv[i] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'd13};

    // Back-to-back message with ready held high
    do_reset();
    tick();
    for (int i = 0; i < 15; i++) begin
      rdy[0] = tv[i].rdy;
      chk($sformatf("t1_valid[%0d]", i), 32'(vld[0]),  32'(tv[i].v));
      chk($sformatf("t1_char[%0d]", i),  32'(chr[0]),  32'(tv[i].c));
      chk($sformatf("t1_busy[%0d]", i),  32'(busy[0]), 32'(tv[i].b));
      chk($sformatf("t1_done[%0d]", i),  32'(done[0]), 32'(tv[i].d));
      chk($sformatf("t1_count[%0d]", i), 32'(cnt[0]),  32'(tv[i].n));
      tick();
    end

    // Random backpressure
    do_reset();
    sbq.delete();
    push_msg();
    mon = 0;
    for (guard = 0; guard < 300 && !done[0]; guard++) begin
      rdy[0] = 1'($urandom_range(0, 1));
      tick();
    end
    chk("t2_done", 32'(done[0]), 32'd1);
    chk("t2_sb_empty", 32'(sbq.size()), 32'd0);
    chk("t2_count", 32'(cnt[0]), 32'd13);
    rdy[0] = 1'b1;

    // Reset with the sixth character pending
    do_reset();
    sbq.delete();
    for (int i = 0; i < 5; i++) sbq.push_back(msg[i]);
    for (guard = 0; guard < 50 && cnt[0] != 16'd5; guard++) tick();
    chk("t5_count5", 32'(cnt[0]), 32'd5);
    chk("t5_pending_valid", 32'(vld[0]), 32'd1);
    chk("t5_pending_char", 32'(chr[0]), 32'h20);
    chk("t5_sb_empty_pre", 32'(sbq.size()), 32'd0);
    rst = 1'b1;
    tick();
    chk("t5_rst_valid", 32'(vld[0]), 32'd0);
    chk("t5_rst_count", 32'(cnt[0]), 32'd0);
    chk("t5_rst_busy", 32'(busy[0]), 32'd0);
    rst = 1'b0;
    push_msg();
    wait_done(0, 100);
    chk("t5_sb_empty", 32'(sbq.size()), 32'd0);
    chk("t5_count", 32'(cnt[0]), 32'd13);
    mon = -1;

    // Three repetitions separated by four idle cycles
    do_reset();
    sbq.delete();
    for (int r = 0; r < 3; r++) push_msg();
    mon = 1;
    tick();
    for (int j = 0; j < 47; j++) begin
      chk($sformatf("t3_valid[%0d]", j), 32'(vld[1]), 32'((j % 17) < 13));
      tick();
    end
    chk("t3_done", 32'(done[1]), 32'd1);
    chk("t3_valid_done", 32'(vld[1]), 32'd0);
    chk("t3_count", 32'(cnt[1]), 32'd39);
    chk("t3_sb_empty", 32'(sbq.size()), 32'd0);
    mon = -1;

    // Manual start, ignored mid-message start, replay from DONE
    do_reset();
    sbq.delete();
    mon = 2;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t4_idle_valid[%0d]", i), 32'(vld[2]), 32'd0);
      chk($sformatf("t4_idle_busy[%0d]", i), 32'(busy[2]), 32'd0);
    end
    push_msg();
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    chk("t4_start_valid", 32'(vld[2]), 32'd1);
    chk("t4_start_count", 32'(cnt[2]), 32'd0);
    repeat (3) tick();
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    wait_done(2, 100);
    chk("t4_sb_empty1", 32'(sbq.size()), 32'd0);
    chk("t4_count1", 32'(cnt[2]), 32'd13);
    chk("t4_done_valid", 32'(vld[2]), 32'd0);
    push_msg();
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    chk("t4_replay_count", 32'(cnt[2]), 32'd0);
    chk("t4_replay_busy", 32'(busy[2]), 32'd1);
    wait_done(2, 100);
    chk("t4_sb_empty2", 32'(sbq.size()), 32'd0);
    chk("t4_count2", 32'(cnt[2]), 32'd13);
    mon = -1;

    // Endless single-character stream saturating the counter
    do_reset();
    tick();
    chk("t6_first_valid", 32'(vld[3]), 32'd1);
    chk("t6_first_char", 32'(chr[3]), 32'h41);
    seen_done = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      tick();
      if (done[3]) seen_done = 1'b1;
      if (i % 8192 == 0) chk("t6_char", 32'(chr[3]), 32'h41);
      if (i == 65533) chk("t6_count_fffe", 32'(cnt[3]), 32'hFFFE);
    end
    chk("t6_count_ffff", 32'(cnt[3]), 32'hFFFF);
    repeat (4) tick();
    chk("t6_count_sat", 32'(cnt[3]), 32'hFFFF);
    chk("t6_valid", 32'(vld[3]), 32'd1);
    chk("t6_char_end", 32'(chr[3]), 32'h41);
    chk("t6_busy", 32'(busy[3]), 32'd1);
    chk("t6_never_done", 32'(seen_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
